// File: rtl/op_encode.sv
// ============================================================================
// Module   : op_encode
// Purpose  : Queues host commands, formats them into op-code/user-data words
//            and issues them under valid/ready with a rolling seq tag and an
//            accept timeout. Optional macro: OPENC_PARITY_EN (adds op_parity).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_encode #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic [15:0] op_code_bus,
    output logic [15:0] user_data_bus,
    output logic        op_valid,
    input  logic        op_ready,
    output logic        err_illegal,
    output logic        err_timeout,
`ifdef OPENC_PARITY_EN
    output logic        op_parity,
`endif
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [1:0]    C_OP_ILLEGAL = 2'd3;
    localparam logic [1:0]    C_OP_CFG_SNS = 2'd1;
    localparam logic [CW-1:0] C_TMO_LAST   = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [25:0]     r_mem [DEPTH];
    logic [AW:0]     r_wptr;
    logic [AW:0]     r_rptr;
    logic [3:0]      r_seq;
    logic [CW-1:0]   r_cnt;
    logic [15:0]     r_op_code;
    logic [15:0]     r_user_data;
    logic            r_op_valid;
    logic            r_err_illegal;
    logic            r_err_timeout;
    logic            r_parity;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_xfer;
    logic            w_tmo;
    logic [25:0]     w_head;
    logic [1:0]      w_head_op;
    logic [3:0]      w_head_opc;
    logic [15:0]     w_head_data;
    logic [15:0]     w_new_code;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = cmd_valid && !w_full && (cmd_op != C_OP_ILLEGAL);

    assign w_head      = r_mem[r_rptr[AW-1:0]];
    assign w_head_op   = w_head[25:24];
    assign w_head_data = (w_head_op == C_OP_CFG_SNS) ? w_head[15:0] : 16'h0000;
    assign w_new_code  = {w_head_opc, w_head[23:16], r_seq};

    always_comb begin
        w_head_opc = 4'h0;
        case (w_head_op)
            2'd0:    w_head_opc = 4'h1;
            2'd1:    w_head_opc = 4'h2;
            2'd2:    w_head_opc = 4'h3;
            default: w_head_opc = 4'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {cmd_op, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_err_illegal <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_err_illegal <= cmd_valid && !w_full && (cmd_op == C_OP_ILLEGAL);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A transfer on the final timeout edge wins over the drop.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_xfer      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (op_ready) begin
                    w_xfer      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_TMO_LAST) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op_code     <= 16'h0000;
            r_user_data   <= 16'h0000;
            r_op_valid    <= 1'b0;
            r_parity      <= 1'b0;
            r_seq         <= 4'h0;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_tmo;
            if (w_pop) begin
                r_op_code   <= w_new_code;
                r_user_data <= w_head_data;
                r_parity    <= ^{w_new_code, w_head_data};
                r_op_valid  <= 1'b1;
                r_cnt       <= '0;
            end else if (w_xfer || w_tmo) begin
                r_op_code   <= 16'h0000;
                r_user_data <= 16'h0000;
                r_parity    <= 1'b0;
                r_op_valid  <= 1'b0;
                r_cnt       <= '0;
                if (w_xfer) begin
                    r_seq <= r_seq + 4'h1;
                end
            end else if (r_state == S_ISSUE) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign cmd_ready     = !w_full;
    assign op_code_bus   = r_op_code;
    assign user_data_bus = r_user_data;
    assign op_valid      = r_op_valid;
    assign err_illegal   = r_err_illegal;
    assign err_timeout   = r_err_timeout;
    assign busy          = (r_state != S_IDLE) || !w_empty;

`ifdef OPENC_PARITY_EN
    assign op_parity = r_parity;
`else
    logic w_parity_unused;
    assign w_parity_unused = r_parity;
`endif

endmodule

`default_nettype wire
